// File: rtl/ysyx_22051013_trap_ctl_pkg.sv
// Shared constants for the trap/redirect controller: FSM encodings, mcause values
// and the flush down-counter width.
package ysyx_22051013_trap_ctl_pkg;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRedir = 2'd1;
  localparam logic [1:0] StFlush = 2'd2;

  // Wide enough for FLUSH_CYCLES up to 15.
  localparam int unsigned FLUSH_CNT_W = 4;

  localparam logic [63:0] ECALL_M    = 64'd11;
  localparam logic [63:0] MTIMER_IRQ = 64'h8000_0000_0000_0007;

endpackage

// File: rtl/ysyx_22051013_trap_ctl.sv
// Commit-boundary trap controller: ecall/mret/timer-interrupt redirect and pipeline flush.
// Timer interrupts are taken only when YSYX_22051013_TIMER_IRQ_EN is defined.
module ysyx_22051013_trap_ctl
  import ysyx_22051013_trap_ctl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_valid,
  input  logic [63:0] wb_pc,
  input  logic        wb_ecall,
  input  logic        wb_mret,
  input  logic        timer_irq,
  input  logic        mstatus_mie,
  input  logic        mie_mtie,
  input  logic [63:0] mtvec,
  input  logic [63:0] mepc,
  output logic        csr_we_trap,
  output logic [63:0] trap_mepc,
  output logic [63:0] trap_mcause,
  output logic        mret_take,
  output logic        redirect_valid,
  output logic [63:0] redirect_pc,
  output logic        flush,
  output logic        wb_kill,
  output logic        busy
);

  logic irq_pend;

`ifdef YSYX_22051013_TIMER_IRQ_EN
  assign irq_pend = timer_irq & mstatus_mie & mie_mtie;
`else
  logic unused_irq;
  assign irq_pend   = 1'b0;
  assign unused_irq = timer_irq ^ mstatus_mie ^ mie_mtie;
`endif

  logic [1:0]             state_q, state_d;
  logic [FLUSH_CNT_W-1:0] cnt_q, cnt_d;
  logic                   trap_q, trap_d;
  logic                   mret_q, mret_d;
  logic [63:0]            tgt_q, tgt_d;
  logic [63:0]            epc_q, epc_d;
  logic [63:0]            cause_q, cause_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    trap_d  = trap_q;
    mret_d  = mret_q;
    tgt_d   = tgt_q;
    epc_d   = epc_q;
    cause_d = cause_q;
    case (state_q)
      StIdle: begin
        // ecall beats mret beats interrupt; a losing interrupt simply stays pending.
        if (wb_valid && (wb_ecall || wb_mret || irq_pend)) begin
          state_d = StRedir;
          trap_d  = wb_ecall || !wb_mret;
          mret_d  = !wb_ecall && wb_mret;
          tgt_d   = (!wb_ecall && wb_mret) ? mepc : mtvec;
          epc_d   = (!wb_ecall && wb_mret) ? 64'd0 : wb_pc;
          cause_d = wb_ecall ? ECALL_M : (wb_mret ? 64'd0 : MTIMER_IRQ);
        end
      end
      StRedir: begin
        state_d = StFlush;
        cnt_d   = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
      end
      StFlush: begin
        if (cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      trap_q  <= 1'b0;
      mret_q  <= 1'b0;
      tgt_q   <= '0;
      epc_q   <= '0;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      trap_q  <= trap_d;
      mret_q  <= mret_d;
      tgt_q   <= tgt_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
    end
  end

  logic in_redir;
  assign in_redir       = (state_q == StRedir);
  assign busy           = (state_q != StIdle);
  assign flush          = busy;
  assign redirect_valid = in_redir;
  assign csr_we_trap    = in_redir & trap_q;
  assign mret_take      = in_redir & mret_q;
  assign redirect_pc    = in_redir ? tgt_q : 64'd0;
  assign trap_mepc      = (in_redir & trap_q) ? epc_q : 64'd0;
  assign trap_mcause    = (in_redir & trap_q) ? cause_q : 64'd0;

  // Interrupted instruction must not retire; anything committing during a flush is squashed.
  assign wb_kill = wb_valid & (busy | (irq_pend & ~wb_ecall & ~wb_mret));

endmodule

// File: tb/tb_ysyx_22051013_trap_ctl.sv
// Self-checking bench: per-cycle vectors are pushed to a scoreboard when driven and
// checked on the falling edge; the interrupt sequences depend on YSYX_22051013_TIMER_IRQ_EN.
module tb_ysyx_22051013_trap_ctl;

  localparam logic [63:0] MTVEC  = 64'h8000_0100;
  localparam logic [63:0] MEPC   = 64'h8000_0014;
  localparam logic [63:0] C_ECL  = 64'd11;
  localparam logic [63:0] C_IRQ  = 64'h8000_0000_0000_0007;
  // Flag order: {csr_we_trap, mret_take, redirect_valid, flush, wb_kill, busy}
  localparam logic [5:0] F_NONE  = 6'b000000;
  localparam logic [5:0] F_KILL  = 6'b000010;
  localparam logic [5:0] F_FL    = 6'b000101;
  localparam logic [5:0] F_FLK   = 6'b000111;
  localparam logic [5:0] F_TRAP  = 6'b101101;
  localparam logic [5:0] F_MRET  = 6'b011101;

  typedef struct {
    logic        rst;
    logic        valid;
    logic [63:0] pc;
    logic        ecall;
    logic        mret;
    logic        irq;
    logic [5:0]  flags;
    logic [63:0] rpc;
    logic [63:0] tepc;
    logic [63:0] tcause;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb_valid = 1'b0;
  logic [63:0] wb_pc = '0;
  logic        wb_ecall = 1'b0;
  logic        wb_mret = 1'b0;
  logic        timer_irq = 1'b0;
  logic        mstatus_mie = 1'b1;
  logic        mie_mtie = 1'b1;
  logic [63:0] mtvec = MTVEC;
  logic [63:0] mepc = MEPC;
  logic        csr_we_trap, mret_take, redirect_valid, flush, wb_kill, busy;
  logic [63:0] trap_mepc, trap_mcause, redirect_pc;

  ysyx_22051013_trap_ctl #(.FLUSH_CYCLES(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .wb_valid       (wb_valid),
    .wb_pc          (wb_pc),
    .wb_ecall       (wb_ecall),
    .wb_mret        (wb_mret),
    .timer_irq      (timer_irq),
    .mstatus_mie    (mstatus_mie),
    .mie_mtie       (mie_mtie),
    .mtvec          (mtvec),
    .mepc           (mepc),
    .csr_we_trap    (csr_we_trap),
    .trap_mepc      (trap_mepc),
    .trap_mcause    (trap_mcause),
    .mret_take      (mret_take),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .flush          (flush),
    .wb_kill        (wb_kill),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  vec_t sb[$];
  vec_t exp_v;
  int   n_vec = 0;
  int   n_bad = 0;
  logic [5:0] act_flags;

  function automatic vec_t mk(input logic r, input logic v, input logic [63:0] pc,
                              input logic ec, input logic mr, input logic irq,
                              input logic [5:0] f, input logic [63:0] rpc,
                              input logic [63:0] tepc, input logic [63:0] tc);
    vec_t x;
    x.rst = r; x.valid = v; x.pc = pc; x.ecall = ec; x.mret = mr; x.irq = irq;
    x.flags = f; x.rpc = rpc; x.tepc = tepc; x.tcause = tc;
    return x;
  endfunction

  task automatic apply(input vec_t x);
    @(posedge clk);
    #1;
    rst       = x.rst;
    wb_valid  = x.valid;
    wb_pc     = x.pc;
    wb_ecall  = x.ecall;
    wb_mret   = x.mret;
    timer_irq = x.irq;
    sb.push_back(x);
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_v = sb.pop_front();
      act_flags = {csr_we_trap, mret_take, redirect_valid, flush, wb_kill, busy};
      n_vec++;
      if (act_flags !== exp_v.flags || redirect_pc !== exp_v.rpc ||
          trap_mepc !== exp_v.tepc || trap_mcause !== exp_v.tcause) begin
        n_bad++;
        $display("FAIL vec%0d: flags got %b exp %b, rpc got %h exp %h, mepc got %h exp %h, mcause got %h exp %h",
                 n_vec, act_flags, exp_v.flags, redirect_pc, exp_v.rpc, trap_mepc, exp_v.tepc,
                 trap_mcause, exp_v.tcause);
      end
    end
  end

  vec_t tbl[22];

  initial begin
    tbl[0]  = mk(1, 0, 0, 0, 0, 0, F_NONE, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0, 0, 0, 0, F_NONE, 0, 0, 0);
    tbl[2]  = mk(0, 1, 64'h8000_0010, 1, 0, 0, F_NONE, 0, 0, 0);
    tbl[3]  = mk(0, 0, 0, 0, 0, 0, F_TRAP, MTVEC, 64'h8000_0010, C_ECL);
    tbl[4]  = mk(0, 0, 0, 0, 0, 0, F_FL, 0, 0, 0);
    tbl[5]  = mk(0, 1, 64'h8000_0018, 0, 0, 0, F_FLK, 0, 0, 0);
    tbl[6]  = mk(0, 0, 0, 0, 0, 0, F_NONE, 0, 0, 0);
    tbl[7]  = mk(0, 1, 64'h8000_0200, 0, 1, 0, F_NONE, 0, 0, 0);
    tbl[8]  = mk(0, 0, 0, 0, 0, 0, F_MRET, MEPC, 0, 0);
    tbl[9]  = mk(0, 0, 0, 0, 0, 0, F_FL, 0, 0, 0);
    tbl[10] = mk(0, 1, 64'h8000_0204, 1, 0, 0, F_FLK, 0, 0, 0);
    tbl[11] = mk(0, 0, 0, 0, 0, 0, F_NONE, 0, 0, 0);
    tbl[12] = mk(0, 1, 64'h8000_0208, 0, 0, 0, F_NONE, 0, 0, 0);
    tbl[13] = mk(0, 1, 64'h8000_0040, 1, 0, 0, F_NONE, 0, 0, 0);
    tbl[14] = mk(0, 0, 0, 0, 0, 0, F_TRAP, MTVEC, 64'h8000_0040, C_ECL);
    tbl[15] = mk(1, 0, 0, 0, 0, 0, F_FL, 0, 0, 0);
    tbl[16] = mk(0, 0, 0, 0, 0, 0, F_NONE, 0, 0, 0);
    tbl[17] = mk(0, 1, 64'h8000_0050, 1, 0, 0, F_NONE, 0, 0, 0);
    tbl[18] = mk(0, 0, 0, 0, 0, 0, F_TRAP, MTVEC, 64'h8000_0050, C_ECL);
    tbl[19] = mk(0, 0, 0, 0, 0, 0, F_FL, 0, 0, 0);
    tbl[20] = mk(0, 0, 0, 0, 0, 0, F_FL, 0, 0, 0);
    tbl[21] = mk(0, 0, 0, 0, 0, 0, F_NONE, 0, 0, 0);

    repeat (2) @(posedge clk);
    foreach (tbl[i]) apply(tbl[i]);

`ifdef YSYX_22051013_TIMER_IRQ_EN
    // Pending interrupt waits for a commit boundary.
    repeat (5) apply(mk(0, 0, 0, 0, 0, 1, F_NONE, 0, 0, 0));
    apply(mk(0, 1, 64'h8000_0020, 0, 0, 1, F_KILL, 0, 0, 0));
    apply(mk(0, 0, 0, 0, 0, 1, F_TRAP, MTVEC, 64'h8000_0020, C_IRQ));
    apply(mk(0, 0, 0, 0, 0, 0, F_FL, 0, 0, 0));
    apply(mk(0, 0, 0, 0, 0, 0, F_FL, 0, 0, 0));
    // ecall wins over a simultaneous interrupt; interrupt taken at the next idle commit.
    apply(mk(0, 1, 64'h8000_0030, 1, 0, 1, F_NONE, 0, 0, 0));
    apply(mk(0, 0, 0, 0, 0, 1, F_TRAP, MTVEC, 64'h8000_0030, C_ECL));
    apply(mk(0, 1, 64'h8000_0100, 0, 0, 1, F_FLK, 0, 0, 0));
    apply(mk(0, 0, 0, 0, 0, 1, F_FL, 0, 0, 0));
    apply(mk(0, 0, 0, 0, 0, 1, F_NONE, 0, 0, 0));
    apply(mk(0, 1, 64'h8000_0034, 0, 0, 1, F_KILL, 0, 0, 0));
    apply(mk(0, 0, 0, 0, 0, 1, F_TRAP, MTVEC, 64'h8000_0034, C_IRQ));
    apply(mk(0, 0, 0, 0, 0, 0, F_FL, 0, 0, 0));
    apply(mk(0, 0, 0, 0, 0, 0, F_FL, 0, 0, 0));
    apply(mk(0, 0, 0, 0, 0, 0, F_NONE, 0, 0, 0));
`else
    // Interrupts disabled at build time: commits with an asserted timer never trap.
    for (int k = 0; k < 100; k++) begin
      apply(mk(0, 1, 64'h8000_1000 + 64'(4 * k), 0, 0, 1, F_NONE, 0, 0, 0));
    end
    apply(mk(0, 0, 0, 0, 0, 1, F_NONE, 0, 0, 0));
`endif

    repeat (3) @(posedge clk);
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d vectors unchecked, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ysyx_22051013_trap_ctl.md
YSYX_22051013_TRAP_CTL -- requirements
Module: ysyx_22051013_trap_ctl

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 2, meaning the number of cycles flush is held after a redirect (legal range 1..15).
REQ-002 SHALL have port clk, input, 1, clock.
REQ-003 SHALL have port rst, input, 1, reset, synchronous, active-high.
REQ-004 SHALL have port wb_valid, input, 1, an instruction is at the commit boundary this cycle.
REQ-005 SHALL have port wb_pc, input, 64, PC of the committing instruction.
REQ-006 SHALL have port wb_ecall, input, 1, the committing instruction is ecall (qualified by wb_valid).
REQ-007 SHALL have port wb_mret, input, 1, the committing instruction is mret (qualified by wb_valid).
REQ-008 SHALL have port timer_irq, input, 1, level timer interrupt from the CLINT.
REQ-009 SHALL have port mstatus_mie / mie_mtie, input, 1 each, global and timer interrupt enables.
REQ-010 SHALL have ports mtvec / mepc, input, 64 each, current CSR values.
REQ-011 SHALL have port csr_we_trap, output, 1, a one-cycle pulse to write mepc/mcause.
REQ-012 SHALL have ports trap_mepc / trap_mcause, output, 64 each, the values written with csr_we_trap.
REQ-013 SHALL have port mret_take, output, 1, a one-cycle pulse to restore mstatus.
REQ-014 SHALL have ports redirect_valid (output, 1) and redirect_pc (output, 64), the fetch redirect.
REQ-015 SHALL have ports flush (output, 1), kill younger stages; wb_kill (output, 1, combinational), suppress the register write and retire of the current wb instruction; busy (output, 1), the FSM is not IDLE.

Function
REQ-016 SHALL implement an FSM with states IDLE, REDIR, FLUSH.
- irq_pend = timer_irq & mstatus_mie & mie_mtie.
REQ-017 In IDLE, wb_valid & wb_ecall SHALL go to REDIR next cycle with csr_we_trap=1, trap_mepc=wb_pc, trap_mcause=11, redirect_pc=mtvec.
REQ-018 In IDLE, wb_valid & wb_mret SHALL go to REDIR with mret_take=1 and redirect_pc=mepc (sampled in that cycle).
REQ-019 In IDLE, wb_valid & irq_pend with neither ecall nor mret SHALL assert wb_kill in the same cycle and go to REDIR with csr_we_trap=1, trap_mepc=wb_pc, trap_mcause=64'h8000000000000007, redirect_pc=mtvec.
REQ-020 On the priority case, ecall/mret at commit SHALL win over irq_pend; the interrupt stays pending and is reevaluated at the next wb_valid in IDLE.
REQ-021 irq_pend without wb_valid SHALL take no action; the controller waits for a commit boundary with no timeout.
REQ-022 REDIR SHALL last exactly one cycle with redirect_valid=1 and flush=1, then go to FLUSH.
REQ-023 FLUSH SHALL hold flush=1 for FLUSH_CYCLES cycles via a down-counter, then return to IDLE; total redirect-to-idle latency is 1+FLUSH_CYCLES.
REQ-024 While busy, wb_valid, wb_ecall, wb_mret and irq_pend SHALL be ignored, and wb_kill SHALL be 1 if wb_valid.
REQ-025 csr_we_trap, mret_take and redirect_valid SHALL each be exactly one-cycle pulses per event.
REQ-026 When idle, redirect_pc, trap_mepc and trap_mcause SHALL be 0.

Reset
REQ-027 On rst: state IDLE, counter 0, all outputs 0; reset mid-FLUSH SHALL abort the sequence with no further pulses.

Configuration
REQ-028 With macro YSYX_22051013_TIMER_IRQ_EN defined, interrupt handling SHALL be as above.
REQ-029 Without YSYX_22051013_TIMER_IRQ_EN, irq_pend SHALL be forced to 0, and timer_irq, mstatus_mie and mie_mtie SHALL be unused; ecall and mret behaviour SHALL be unchanged.

Structure
REQ-030 FSM state encodings, the mcause constants (ECALL_M=11, MTIMER_IRQ=64'h8000000000000007) and the flush counter width SHALL live in the shared package/define.v.
REQ-031 The block SHALL be a single module with no sub-module; the CSR file stays external.

Verification
REQ-032 ecall at wb_pc=0x80000010, mtvec=0x80000100 -> next cycle csr_we_trap=1, trap_mcause=11, trap_mepc=0x80000010, redirect_pc=0x80000100; flush high 3 cycles (FLUSH_CYCLES=2).
REQ-033 mret with mepc=0x80000014 -> mret_take=1, redirect_pc=0x80000014, no csr_we_trap.
REQ-034 irq_pend high for 5 cycles with wb_valid=0, then wb_valid at pc 0x80000020 -> wb_kill that cycle, mcause=0x8000000000000007, mepc=0x80000020.
REQ-035 ecall and irq_pend in the same commit cycle -> ecall trap taken; interrupt taken at the first wb_valid after the FSM returns to IDLE.
REQ-036 rst asserted during FLUSH -> next cycle all outputs 0, busy=0; a later ecall is handled normally.
REQ-037 Build without YSYX_22051013_TIMER_IRQ_EN, timer_irq=1 with enables set -> no wb_kill and no trap over 100 commits.
